// File: rtl/ppwm_pkg.sv
// Shared types for the PPWM timer and its execution stage.
package ppwm_pkg;

  typedef enum logic {
    StIdle,
    StRun
  } ppwm_state_e;

  typedef enum logic [1:0] {
    CmdNop,
    CmdSet,
    CmdClear,
    CmdToggle
  } ppwm_cmd_e;

  typedef enum logic [1:0] {
    TgtPeriod,
    TgtDuty,
    TgtPolarity,
    TgtEnable
  } ppwm_target_e;

endpackage

// File: rtl/ppwm_timer.sv
// Period/duty PWM timer: shadowed period and duty, period-start pulse and
// a global {period index, intra-period count} counter for the execution stage.
module ppwm_timer
  import ppwm_pkg::*;
#(
  parameter int COUNTER_WIDTH        = 10,
  parameter int GLOBAL_COUNTER_WIDTH = 20
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en_i,
  input  logic [COUNTER_WIDTH-1:0]        period_i,
  input  logic [COUNTER_WIDTH-1:0]        pwm_value_i,
  input  logic                            polarity_i,
  output logic                            start_o,
  output logic [GLOBAL_COUNTER_WIDTH-1:0] global_counter_o,
  output logic                            pwm_o
);

  localparam int IDX_W = GLOBAL_COUNTER_WIDTH - COUNTER_WIDTH;

  ppwm_state_e              state_q, state_d;
  logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [COUNTER_WIDTH-1:0] per_q, per_d;
  logic [COUNTER_WIDTH-1:0] duty_q, duty_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its peers, regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      per_q   <= '0;
      duty_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
      duty_q  <= duty_d;
    end
  end

  // NOTE: every variable gets its hold value first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    per_d   = per_q;
    duty_d  = duty_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (en_i) begin
          state_d = StRun;
          per_d   = period_i;
          duty_d  = pwm_value_i;
        end
      end
      StRun: begin
        // Dropping enable wins over a wrap: counters clear, shadows hold.
        if (!en_i) begin
          state_d = StIdle;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == per_q) begin
          cnt_d  = '0;
          idx_d  = idx_q + IDX_W'(1);
          per_d  = period_i;
          duty_d = pwm_value_i;
        end else begin
          cnt_d = cnt_q + COUNTER_WIDTH'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign start_o          = (state_q == StRun) && (cnt_q == '0);
  assign global_counter_o = {idx_q, cnt_q};
  assign pwm_o            = ((state_q == StRun) && (cnt_q < duty_q)) ^ polarity_i;

endmodule

// File: tb/tb_ppwm_timer.sv
// Directed scoreboard bench for ppwm_timer with default widths.
module tb_ppwm_timer;

  localparam int CW = 10;
  localparam int GW = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CW-1:0] period;
  logic [CW-1:0] pwm_value;
  logic          polarity;
  logic          start;
  logic [GW-1:0] gc;
  logic          pwm;

  typedef struct packed {
    logic          start;
    logic [GW-1:0] gc;
    logic          pwm;
  } exp_t;

  exp_t exp_q[$];
  int   passes = 0;
  int   total  = 0;
  int   fails  = 0;

  ppwm_timer #(
    .COUNTER_WIDTH       (CW),
    .GLOBAL_COUNTER_WIDTH(GW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en_i            (en),
    .period_i        (period),
    .pwm_value_i     (pwm_value),
    .polarity_i      (polarity),
    .start_o         (start),
    .global_counter_o(gc),
    .pwm_o           (pwm)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic s, input int idx, input int cnt, input logic p);
    exp_t e;
    e.start = s;
    e.gc    = GW'((idx % 1024) * 1024 + cnt);
    e.pwm   = p;
    return e;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string tag);
    exp_t e;
    e = exp_q.pop_front();
    cmp({tag, " start"}, 32'(start), 32'(e.start));
    cmp({tag, " gc"}, 32'(gc), 32'(e.gc));
    cmp({tag, " pwm"}, 32'(pwm), 32'(e.pwm));
  endtask

  task automatic expect_now(input string tag, input exp_t e);
    exp_q.push_back(e);
    check_head(tag);
  endtask

  // Expectation for the state produced by the next rising edge.
  task automatic step(input string tag, input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_head(tag);
  endtask

  initial begin
    int c;
    int k;
    int duty;
    logic act;

    rst       = 1'b1;
    en        = 1'b0;
    period    = 10'd9;
    pwm_value = 10'd3;
    polarity  = 1'b0;

    step("reset", mk(0, 0, 0, 0));
    step("reset hold", mk(0, 0, 0, 0));
    polarity = 1'b1;
    #1;
    expect_now("reset pol", mk(0, 0, 0, 1));
    polarity = 1'b0;
    en = 1'b1;
    step("reset over en", mk(0, 0, 0, 0));

    // Basic waveform, shadowed duty change at cnt=5, enable drop at cnt=4.
    rst = 1'b0;
    for (int j = 0; j <= 54; j++) begin
      c    = j % 10;
      duty = (j < 40) ? 3 : 7;
      step($sformatf("basic j=%0d", j), mk(c == 0, j / 10, c, c < duty));
      if (j == 35) pwm_value = 10'd7;
    end
    en = 1'b0;
    step("en drop", mk(0, 0, 0, 0));
    step("idle", mk(0, 0, 0, 0));
    en = 1'b1;
    step("re-enable", mk(1, 0, 0, 1));

    // Edge duties: 0 then 12 (> period), polarity flipped for the last two.
    en = 1'b0;
    step("idle2", mk(0, 0, 0, 0));
    pwm_value = 10'd0;
    en = 1'b1;
    for (int j = 0; j < 40; j++) begin
      k   = j / 10;
      c   = j % 10;
      act = (k == 1) || (k == 2);
      step($sformatf("edge j=%0d", j), mk(c == 0, k, c, act ^ (k >= 2)));
      if (c == 9) begin
        if (k == 0) pwm_value = 10'd12;
        if (k == 1) polarity = 1'b1;
        if (k == 2) pwm_value = 10'd0;
      end
    end
    en = 1'b0;
    step("idle3", mk(0, 0, 0, 1));

    // Zero period: start every cycle, index wraps 1023 -> 0.
    polarity  = 1'b0;
    period    = 10'd0;
    pwm_value = 10'd1;
    en        = 1'b1;
    for (int j = 0; j < 1030; j++) begin
      step($sformatf("zero j=%0d", j), mk(1, j, 0, 1));
    end

    // Enable drop coinciding with a wrap.
    period    = 10'd9;
    pwm_value = 10'd5;
    en        = 1'b0;
    step("drop at wrap", mk(0, 0, 0, 0));
    step("idle4", mk(0, 0, 0, 0));

    // Reset mid-period at cnt=6.
    pwm_value = 10'd3;
    en        = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      step($sformatf("pre-rst j=%0d", j), mk(j == 0, 0, j, j < 3));
    end
    rst = 1'b1;
    step("rst mid", mk(0, 0, 0, 0));
    polarity = 1'b1;
    #1;
    expect_now("rst mid pol", mk(0, 0, 0, 1));
    polarity = 1'b0;
    step("rst hold", mk(0, 0, 0, 0));
    rst = 1'b0;
    step("after rst", mk(1, 0, 0, 1));
    for (int j = 1; j <= 3; j++) begin
      step($sformatf("post-rst j=%0d", j), mk(0, 0, j, j < 3));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
